rr_onoff_arbiter: RTL and testbench
===================================

// Module: rr_onoff_arbiter
// PURPOSE
//   Round-robin arbiter granting one shared ON/OFF resource to N requesters.
//   A request turns the grant ON, the owner's release or a hold timeout turns
//   it OFF. It sits in front of the two-state resource FSM and drives that
//   resource's on/off inputs for whichever requester currently owns it.
// PARAMETERS
//   N        4   number of requesters (>= 2)
//   TIMEOUT  15  max consecutive cycles one grant may be held; 0 = no timeout
// PORTS
//   clk            input   1          clock, rising edge
//   areset         input   1          reset, asynchronous, active-high
//   req            input   N          request per requester; sampled only in IDLE
//   rel            input   N          release per requester; only rel[owner] acts
//   grant          output  N          one-hot grant, all-zero when free
//   busy           output  1          high while grant != 0
//   owner          output  clog2(N)   index of granted requester; valid when busy
//   timeout_pulse  output  1          1-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//   - All outputs registered. On areset: state=IDLE, ptr=0, cnt=0, grant=0,
//     busy=0, owner=0, timeout_pulse=0. Reset mid-grant drops grant at once.
//   - States: IDLE, GRANT, RECOVER.
//   - IDLE: if req != 0, pick the first set req[i] scanning ptr, ptr+1, ...
//     (mod N). Next edge: GRANT, grant=onehot(i), owner=i, busy=1, cnt=1.
//     If req == 0, stay IDLE. Latency: req sampled at edge k, grant high after k.
//   - GRANT: grant held regardless of req changes.
//     * rel[owner]=1 -> RECOVER (release wins even if cnt==TIMEOUT; no pulse).
//     * else TIMEOUT!=0 and cnt==TIMEOUT -> RECOVER, timeout_pulse=1 for that
//       RECOVER cycle only.
//     * else cnt<=cnt+1; stay GRANT. Grant is high exactly TIMEOUT cycles on timeout.
//     * rel[j], j!=owner: ignored. On leaving GRANT: ptr <= (owner+1) mod N.
//   - RECOVER: grant=0, busy=0; always -> IDLE next edge (req ignored).
//     Grant is low exactly 2 cycles between consecutive owners (RECOVER, IDLE).
//   - owner retains its last value while not busy.
//   - cnt width clog2(TIMEOUT+1), min 1; saturates (never wraps) when TIMEOUT=0.
//   - grant is always zero or one-hot; busy == |grant.
// TESTING (N=4, TIMEOUT=5)
//   1. areset pulse, req=0000 for 10 cycles -> grant=0000, busy=0, timeout_pulse=0 throughout.
//   2. req=0101, ptr=0 -> grant=0001 one cycle later, owner=0; rel=0001 -> grant 0 for 2 cycles, then grant=0100, owner=2.
//   3. req=0010 held, rel=0 -> grant=0010 for exactly 5 cycles, timeout_pulse=1 in the first grant-0 cycle, regrant 0010 2 cycles later.
//   4. owner=2, rel=1011 for 3 cycles -> grant stays 0100; rel=0100 -> grant drops next edge.
//   5. rel[owner]=1 in the cycle cnt==5 -> grant drops, timeout_pulse stays 0, ptr=owner+1.
//   6. areset asserted mid-GRANT between clock edges -> grant=0, busy=0 immediately; after release, req=1000 -> grant=1000 (ptr=0 scan).

Source files
------------

// File: rtl/rr_onoff_arbiter.sv
// Round-robin arbiter that hands one shared ON/OFF resource to one of N requesters,
// revoking it on the owner's release or after TIMEOUT consecutive held cycles.
module rr_onoff_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         rel,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout_pulse,
    output logic [1:0]           fsm_state
);

    localparam int OW = $clog2(N);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [OW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  grant_n;
    logic          busy_n;
    logic [OW-1:0] owner_n;
    logic          pulse_n;

    logic          found;
    logic [OW-1:0] pick;
    logic [OW-1:0] owner_inc;
    int            idx;

    assign fsm_state = state;

    // First set request scanning upward from ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    assign owner_inc = (int'(owner) == N - 1) ? '0 : owner + 1'b1;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        grant_n = grant;
        busy_n  = busy;
        owner_n = owner;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    grant_n = N'(1) << pick;
                    owner_n = pick;
                    busy_n  = 1'b1;
                    cnt_n   = CW'(1);
                end
            end
            GRANT: begin
                // Release takes priority over an expiring hold count.
                if (rel[owner]) begin
                    state_n = RECOVER;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    ptr_n   = owner_inc;
                end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT)) begin
                    state_n = RECOVER;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    ptr_n   = owner_inc;
                    pulse_n = 1'b1;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RECOVER: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            owner         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            cnt           <= cnt_n;
            grant         <= grant_n;
            busy          <= busy_n;
            owner         <= owner_n;
            timeout_pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_rr_onoff_arbiter.sv
// Directed bench for rr_onoff_arbiter (N=4, TIMEOUT=5) with hand-computed expectations.
module tb_rr_onoff_arbiter;

    logic       clk;
    logic       areset;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
    logic       timeout_pulse;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;
    int held;

    rr_onoff_arbiter #(.N(4), .TIMEOUT(5)) dut (
        .clk           (clk),
        .areset        (areset),
        .req           (req),
        .rel           (rel),
        .grant         (grant),
        .busy          (busy),
        .owner         (owner),
        .timeout_pulse (timeout_pulse),
        .fsm_state     (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] o,
                              input logic tp);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".busy"}, 32'(busy), 32'(g != 4'b0));
        if (g != 4'b0) check({tag, ".owner"}, 32'(owner), 32'(o));
        check({tag, ".tpulse"}, 32'(timeout_pulse), 32'(tp));
    endtask

    initial begin
        areset = 1'b1;
        req    = 4'b0;
        rel    = 4'b0;
        #2;
        check("rst.grant", 32'(grant), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.owner", 32'(owner), 32'h0);
        check("rst.tpulse", 32'(timeout_pulse), 32'h0);
        check("rst.state", 32'(fsm_state), 32'h0);
        #11;
        areset = 1'b0;

        // 1: idle with no requests
        for (int i = 0; i < 10; i++) begin
            step();
            check_outs("idle", 4'b0000, 2'd0, 1'b0);
        end

        // 2: req 0101 from ptr 0 -> owner 0, then rotate to owner 2
        req = 4'b0101;
        step();
        check_outs("t2.g0", 4'b0001, 2'd0, 1'b0);
        rel = 4'b0001;
        step();
        check_outs("t2.rec", 4'b0000, 2'd0, 1'b0);
        check("t2.state_rec", 32'(fsm_state), 32'h2);
        rel = 4'b0000;
        step();
        check_outs("t2.idle", 4'b0000, 2'd0, 1'b0);
        step();
        check_outs("t2.g2", 4'b0100, 2'd2, 1'b0);

        // 4: foreign releases ignored, owner release drops grant
        rel = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("t4.hold", 4'b0100, 2'd2, 1'b0);
        end
        rel = 4'b0100;
        step();
        check_outs("t4.drop", 4'b0000, 2'd2, 1'b0);
        check("t4.owner_kept", 32'(owner), 32'h2);

        // 3: held request times out after exactly 5 grant cycles
        rel = 4'b0000;
        req = 4'b0010;
        step();
        check_outs("t3.idle", 4'b0000, 2'd0, 1'b0);
        step();
        check_outs("t3.g1", 4'b0010, 2'd1, 1'b0);
        held = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant != 4'b0010) break;
            held++;
        end
        check("t3.held_cycles", 32'(held), 32'd5);
        check_outs("t3.timeout", 4'b0000, 2'd1, 1'b1);
        step();
        check_outs("t3.after", 4'b0000, 2'd1, 1'b0);
        step();
        check_outs("t3.regrant", 4'b0010, 2'd1, 1'b0);

        // 5: release on the cnt==5 cycle beats the timeout
        for (int i = 0; i < 4; i++) begin
            step();
            check_outs("t5.hold", 4'b0010, 2'd1, 1'b0);
        end
        rel = 4'b0010;
        req = 4'b0000;
        step();
        check_outs("t5.rel", 4'b0000, 2'd1, 1'b0);
        rel = 4'b0000;
        req = 4'b1111;
        step();
        check_outs("t5.idle", 4'b0000, 2'd1, 1'b0);
        step();
        check_outs("t5.ptr", 4'b0100, 2'd2, 1'b0);

        // 6: asynchronous reset mid-grant, then ptr restarts at 0
        req = 4'b0000;
        #2;
        areset = 1'b1;
        #1;
        check("t6.grant", 32'(grant), 32'h0);
        check("t6.busy", 32'(busy), 32'h0);
        check("t6.owner", 32'(owner), 32'h0);
        check("t6.state", 32'(fsm_state), 32'h0);
        #2;
        areset = 1'b0;
        req = 4'b1000;
        step();
        check_outs("t6.g3", 4'b1000, 2'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
